// File: rtl/chess_move_pkg.sv
// rtl/chess_move_pkg.sv - shared constants, FSM states and end-marker test for the move reader
package chess_move_pkg;

  localparam int SQW   = 6;
  localparam int NCOL  = 8;
  localparam int SLOTS = 8;
  localparam int WORDW = SQW * (SLOTS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAITC = 3'd1,
    READ  = 3'd2,
    LOAD  = 3'd3,
    EMIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // A word whose every destination equals its source carries no moves and closes the column
  function automatic logic is_end_marker(input logic [WORDW-1:0] word);
    logic [SQW-1:0] src;
    logic           all_eq;
    src    = word[WORDW-1 -: SQW];
    all_eq = 1'b1;
    for (int k = 0; k < SLOTS; k++) begin
      if (word[k*SQW +: SQW] != src) all_eq = 1'b0;
    end
    return all_eq;
  endfunction

endpackage

// File: rtl/move_slot_scanner.sv
// rtl/move_slot_scanner.sv - next-slot selection, skip detect and last-slot flag for one FIFO word
module move_slot_scanner #(
  parameter int SQW   = chess_move_pkg::SQW,
  parameter int SLOTS = chess_move_pkg::SLOTS,
  localparam int SPW  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic [SLOTS*SQW-1:0] dst,
  input  logic [SQW-1:0]       src,
  input  logic [SPW-1:0]       slot_ptr,
  output logic                 last,
  output logic [SPW-1:0]       next_ptr,
  output logic [SQW-1:0]       next_dst,
  output logic                 next_skip
);

  // Look one slot ahead so the top can register mv_valid/mv_data for the following cycle
  always_comb begin
    last      = (slot_ptr == SPW'(SLOTS - 1));
    next_ptr  = last ? '0 : slot_ptr + 1'b1;
    next_dst  = dst[next_ptr*SQW +: SQW];
    next_skip = (next_dst == src);
  end

endmodule

// File: rtl/move_list_reader.sv
// rtl/move_list_reader.sv - drains per-column move FIFOs into a single {src,dst} move stream
module move_list_reader
  import chess_move_pkg::*;
#(
  parameter int NCOL  = chess_move_pkg::NCOL,
  parameter int SLOTS = chess_move_pkg::SLOTS,
  parameter int SQW   = chess_move_pkg::SQW
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NCOL-1:0]                   col_done,
  output logic [NCOL-1:0]                   col_rden,
  input  logic [NCOL*(SQW*(SLOTS+1))-1:0]   col_rd,
  output logic                              mv_valid,
  input  logic                              mv_ready,
  output logic [2*SQW-1:0]                  mv_data,
  output logic [7:0]                        mv_count,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int WW  = SQW * (SLOTS + 1);
  localparam int CPW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int SPW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  state_t           state;
  logic [CPW-1:0]   col_ptr;
  logic [SPW-1:0]   slot_ptr;
  logic [WW-1:0]    word;
  logic [WW-1:0]    rd_word;
  logic [SQW-1:0]   rd_src;
  logic [SQW-1:0]   word_src;
  logic [NCOL-1:0]  ptr_onehot;
  logic             scan_last;
  logic [SPW-1:0]   scan_next_ptr;
  logic [SQW-1:0]   scan_next_dst;
  logic             scan_next_skip;

  assign rd_word    = col_rd[col_ptr*WW +: WW];
  assign rd_src     = rd_word[WW-1 -: SQW];
  assign word_src   = word[WW-1 -: SQW];
  assign ptr_onehot = NCOL'(1) << col_ptr;
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

  move_slot_scanner #(
    .SQW   (SQW),
    .SLOTS (SLOTS)
  ) u_scan (
    .dst       (word[SLOTS*SQW-1:0]),
    .src       (word_src),
    .slot_ptr  (slot_ptr),
    .last      (scan_last),
    .next_ptr  (scan_next_ptr),
    .next_dst  (scan_next_dst),
    .next_skip (scan_next_skip)
  );

  // Drain FSM: wait for each column, read its words one at a time and stream out non-empty slots
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      col_ptr  <= '0;
      slot_ptr <= '0;
      word     <= '0;
      col_rden <= '0;
      mv_valid <= 1'b0;
      mv_data  <= '0;
      mv_count <= '0;
      err      <= 1'b0;
    end else begin
      col_rden <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= WAITC;
            col_ptr  <= '0;
            mv_count <= '0;
            err      <= 1'b0;
          end
        end
        WAITC: begin
          if (col_done[col_ptr]) begin
            state    <= READ;
            col_rden <= ptr_onehot;
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          word     <= rd_word;
          slot_ptr <= '0;
          if (rd_src[SQW-1 -: CPW] != col_ptr) err <= 1'b1;
          if (is_end_marker(rd_word)) begin
            if (col_ptr == CPW'(NCOL - 1)) begin
              state <= DONE;
            end else begin
              col_ptr <= col_ptr + 1'b1;
              state   <= WAITC;
            end
          end else begin
            state    <= EMIT;
            mv_valid <= (rd_word[SQW-1:0] != rd_src);
            mv_data  <= {rd_src, rd_word[SQW-1:0]};
          end
        end
        EMIT: begin
          if (!mv_valid || mv_ready) begin
            if (mv_valid && mv_count != 8'hFF) mv_count <= mv_count + 1'b1;
            if (scan_last) begin
              mv_valid <= 1'b0;
              state    <= READ;
              col_rden <= ptr_onehot;
            end else begin
              slot_ptr <= scan_next_ptr;
              mv_valid <= !scan_next_skip;
              mv_data  <= {word_src, scan_next_dst};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_list_reader.sv
// tb/tb_move_list_reader.sv - directed self-checking bench for move_list_reader
module tb_move_list_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   col_done;
  logic [7:0]   col_rden;
  logic [431:0] col_rd;
  logic         mv_valid;
  logic         mv_ready;
  logic [11:0]  mv_data;
  logic [7:0]   mv_count;
  logic         busy;
  logic         done;
  logic         err;

  logic [53:0]  fifo_mem [8][4];
  int           rdp [8];
  int           rden_cnt [8];
  int           first_col;
  logic [11:0]  mv_log [$];
  logic         tb_clr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  move_list_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .col_done (col_done),
    .col_rden (col_rden),
    .col_rd   (col_rd),
    .mv_valid (mv_valid),
    .mv_ready (mv_ready),
    .mv_data  (mv_data),
    .mv_count (mv_count),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Column FIFO model (word appears the cycle after rden) plus read/move monitor
  always @(posedge clk) begin
    if (tb_clr) begin
      col_rd    <= '0;
      first_col <= -1;
      for (int i = 0; i < 8; i++) begin
        rdp[i]      <= 0;
        rden_cnt[i] <= 0;
      end
      mv_log.delete();
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (col_rden[i]) begin
          col_rd[i*54 +: 54] <= fifo_mem[i][rdp[i] & 3];
          rdp[i]             <= rdp[i] + 1;
          rden_cnt[i]        <= rden_cnt[i] + 1;
          if (first_col < 0) first_col <= i;
        end
      end
      if (mv_valid && mv_ready) mv_log.push_back(mv_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [53:0] end_word(input int i);
    logic [5:0] s;
    s = 6'(8 * i);
    return {s, {8{s}}};
  endfunction

  function automatic logic [53:0] mk_word(input logic [5:0] src, input logic [47:0] dsts);
    return {src, dsts};
  endfunction

  function automatic int total_rden();
    int t;
    t = 0;
    for (int i = 0; i < 8; i++) t += rden_cnt[i];
    return t;
  endfunction

  function automatic logic [11:0] log_at(input int k);
    if (mv_log.size() > k) return mv_log[k];
    return 12'hFFF;
  endfunction

  task automatic fill_empty();
    for (int i = 0; i < 8; i++)
      for (int d = 0; d < 4; d++) fifo_mem[i][d] = end_word(i);
  endtask

  task automatic clr();
    @(negedge clk) tb_clr = 1'b1;
    @(negedge clk) tb_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!mv_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, mv_valid, 1);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    col_done = 8'h00;
    mv_ready = 1'b1;
    tb_clr   = 1'b1;
    fill_empty();
    repeat (3) @(negedge clk);

    // reset state
    check("rst_rden", col_rden, 0);
    check("rst_valid", mv_valid, 0);
    check("rst_data", mv_data, 0);
    check("rst_count", mv_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset  = 1'b1;
    tb_clr = 1'b0;

    // all columns hold only an end marker
    fill_empty();
    col_done = 8'hFF;
    clr();
    pulse_start();
    wait_done("t1_done");
    check("t1_rden_total", total_rden(), 8);
    check("t1_moves", mv_log.size(), 0);
    check("t1_count", mv_count, 0);
    check("t1_err", err, 0);

    // two moves in column 0 with back-pressure on the first
    fill_empty();
    fifo_mem[0][0] = mk_word(6'o01, {6'o01, 6'o01, 6'o01, 6'o01, 6'o01, 6'o01, 6'o03, 6'o02});
    fifo_mem[0][1] = end_word(0);
    mv_ready = 1'b0;
    clr();
    pulse_start();
    wait_valid("t2_valid");
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_data", mv_data, 12'o0102);
      check("t2_hold_valid", mv_valid, 1);
      @(negedge clk);
    end
    check("t2_no_early_accept", mv_log.size(), 0);
    mv_ready = 1'b1;
    wait_done("t2_done");
    check("t2_moves", mv_log.size(), 2);
    check("t2_move0", log_at(0), 12'o0102);
    check("t2_move1", log_at(1), 12'o0103);
    check("t2_count", mv_count, 2);
    check("t2_col0_reads", rden_cnt[0], 2);
    check("t2_rden_total", total_rden(), 9);

    // column 2 word with wrong source column sets err but still emits
    fill_empty();
    fifo_mem[2][0] = mk_word(6'o41, {6'o41, 6'o41, 6'o41, 6'o41, 6'o41, 6'o33, 6'o41, 6'o22});
    fifo_mem[2][1] = end_word(2);
    clr();
    pulse_start();
    wait_done("t3_done");
    check("t3_err", err, 1);
    check("t3_moves", mv_log.size(), 2);
    check("t3_move0", log_at(0), 12'o4122);
    check("t3_move1", log_at(1), 12'o4133);
    check("t3_count", mv_count, 2);

    // restart from DONE with column 3 held back
    fill_empty();
    col_done = 8'hF7;
    clr();
    pulse_start();
    check("t4_err_clr", err, 0);
    check("t4_count_clr", mv_count, 0);
    check("t4_busy", busy, 1);
    repeat (20) @(negedge clk);
    check("t4_col3_no_read", rden_cnt[3], 0);
    check("t4_busy_wait", busy, 1);
    check("t4_reads_before", total_rden(), 3);
    check("t4_not_done", done, 0);
    col_done = 8'hFF;
    wait_done("t4_done");
    check("t4_col3_read", rden_cnt[3], 1);
    check("t4_rden_total", total_rden(), 8);

    // reset while a move is pending
    fill_empty();
    fifo_mem[0][0] = mk_word(6'o01, {6'o01, 6'o01, 6'o01, 6'o01, 6'o01, 6'o01, 6'o03, 6'o02});
    fifo_mem[0][1] = end_word(0);
    mv_ready = 1'b0;
    clr();
    pulse_start();
    wait_valid("t5_valid");
    reset = 1'b0;
    #1;
    check("t5_rst_valid", mv_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_count", mv_count, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_rden", col_rden, 0);
    @(negedge clk);
    check("t5_no_handoff", mv_log.size(), 0);
    reset    = 1'b1;
    mv_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_idle_after_rel", busy, 0);
    clr();
    pulse_start();
    wait_done("t5_done");
    check("t5_first_col", first_col, 0);
    check("t5_move0", log_at(0), 12'o0102);
    check("t5_move1", log_at(1), 12'o0103);
    check("t5_count", mv_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
